// File: rtl/output_gain_if.sv
// Audio stream, level setting and status bundle for the output gain stage.
interface output_gain_if;
    logic signed [15:0] inWave;
    logic [3:0]         num2;
    logic [3:0]         num1;
    logic [3:0]         num0;
    logic               neg;
    logic               mute;
    logic signed [15:0] outWave;
    logic [15:0]        gain_q;
    logic               ramping;
    logic               clip;
    logic               bad_set;

    modport master (
        output inWave, num2, num1, num0, neg, mute,
        input  outWave, gain_q, ramping, clip, bad_set
    );

    modport slave (
        input  inWave, num2, num1, num0, neg, mute,
        output outWave, gain_q, ramping, clip, bad_set
    );
endinterface

// File: rtl/output_gain.sv
// Output gain stage: BCD dB setting -> debounced Q3.13 target, ramped gain,
// two-stage rounding/saturating multiply on the 48 kHz sample stream.
module output_gain #(
    parameter int unsigned SETTLE_SAMPLES    = 480,
    parameter int unsigned RAMP_STEP         = 64,
    parameter int unsigned MAX_BOOST_HALF_DB = 24,
    parameter int unsigned MAX_ATTEN_HALF_DB = 120
) (
    input  logic           clk_48,
    input  logic           reset,
    output_gain_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int unsigned ROM_N = 256;
    localparam logic [15:0] UNITY = 16'h2000;
    localparam logic [15:0] STEP  = 16'(RAMP_STEP);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] SETTLE_HIT = CNT_W'(SETTLE_SAMPLES - 1);

    // Full 8-bit index range; entries past the clamp repeat the clamp value.
    logic [15:0] boost_rom [ROM_N];
    logic [15:0] atten_rom [ROM_N];

    for (genvar i = 0; i < ROM_N; i++) begin : g_rom
        localparam int unsigned HB = (i > MAX_BOOST_HALF_DB) ? MAX_BOOST_HALF_DB : i;
        localparam int unsigned HA = (i > MAX_ATTEN_HALF_DB) ? MAX_ATTEN_HALF_DB : i;
        localparam real GB = 8192.0 * (10.0 ** (real'(HB) / 40.0));
        localparam real GA = 8192.0 * (10.0 ** (-real'(HA) / 40.0));
        localparam logic [15:0] VB = 16'($rtoi(GB + 0.5));
        localparam logic [15:0] VA = 16'($rtoi(GA + 0.5));
        assign boost_rom[i] = VB;
        assign atten_rom[i] = VA;
    end

    logic [12:0]               w;
    logic [12:0]               w_q;
    logic [CNT_W-1:0]          settle_cnt;
    logic [15:0]               target;
    logic                      same;
    logic                      settle_now;
    logic                      digits_ok;
    logic [7:0]                h_idx;
    logic [15:0]               rom_val;
    logic [15:0]               eff_target;
    logic [15:0]               gain_next;
    logic [15:0]               gain_r;
    logic                      ramping_r;
    logic                      bad_set_r;
    logic signed [15:0]        x_q;
    logic [15:0]               g_q;
    logic signed [32:0]        prod;
    logic signed [32:0]        y_full;
    logic signed [15:0]        y_sat;
    logic                      sat_hit;
    logic signed [15:0]        out_r;
    logic                      clip_r;

    assign w = {bus.neg, bus.num2, bus.num1, bus.num0};

    // Setting decode: debounce qualifier and ROM lookup of the held word.
    always_comb begin
        same       = (w == w_q);
        settle_now = same && (settle_cnt == SETTLE_HIT);
        digits_ok  = (w_q[11:8] <= 4'd9) && (w_q[7:4] <= 4'd9) && (w_q[3:0] <= 4'd9);
        h_idx      = 8'(w_q[11:8]) * 8'd20 + 8'(w_q[7:4]) * 8'd2
                   + ((w_q[3:0] >= 4'd5) ? 8'd1 : 8'd0);
        rom_val    = w_q[12] ? atten_rom[h_idx] : boost_rom[h_idx];
    end

    // Ramp toward the effective target, never more than STEP per sample.
    always_comb begin
        eff_target = bus.mute ? 16'd0 : target;
        gain_next  = gain_r;
        if (gain_r < eff_target) begin
            gain_next = ((eff_target - gain_r) > STEP) ? gain_r + STEP : eff_target;
        end else if (gain_r > eff_target) begin
            gain_next = ((gain_r - eff_target) > STEP) ? gain_r - STEP : eff_target;
        end
    end

    // Stage-2 multiply, round half up at bit 13, saturate to 16 bits.
    always_comb begin
        prod    = 33'(x_q) * 33'($signed({1'b0, g_q}));
        y_full  = (prod + 33'sd4096) >>> 13;
        sat_hit = 1'b0;
        y_sat   = 16'(y_full);
        if (y_full > 33'sd32767) begin
            y_sat   = 16'sh7fff;
            sat_hit = 1'b1;
        end else if (y_full < -33'sd32768) begin
            y_sat   = -16'sh8000;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            w_q        <= '0;
            settle_cnt <= '0;
            target     <= UNITY;
            bad_set_r  <= 1'b0;
            gain_r     <= '0;
            ramping_r  <= 1'b0;
            x_q        <= '0;
            g_q        <= '0;
            out_r      <= '0;
            clip_r     <= 1'b0;
        end else begin
            w_q <= w;
            if (!same) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
            if (settle_now) begin
                if (!digits_ok) begin
                    bad_set_r <= 1'b1;
                end else begin
                    bad_set_r <= 1'b0;
                    target    <= rom_val;
                end
            end
            gain_r    <= gain_next;
            ramping_r <= (gain_next != eff_target);
            x_q       <= bus.inWave;
            g_q       <= gain_r;
            out_r     <= y_sat;
            clip_r    <= sat_hit;
        end
    end

    assign bus.outWave = out_r;
    assign bus.gain_q  = gain_r;
    assign bus.ramping = ramping_r;
    assign bus.clip    = clip_r;
    assign bus.bad_set = bad_set_r;

endmodule

// File: tb/tb_output_gain.sv
// Bench for output_gain: directed vector table, corner sequences, and a
// randomized run against a dB-formula reference model in lockstep.
module tb_output_gain;

    logic clk_48 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_48 = ~clk_48;

    output_gain_if bus();

    output_gain dut (
        .clk_48 (clk_48),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_48);
    endtask

    // Gain for a BCD dB setting: round(8192 * 10^(+-h/40)), h clamped.
    function automatic int rom_ref(input bit n, input logic [3:0] d2, input logic [3:0] d1,
                                   input logic [3:0] d0);
        int  h;
        real e;
        h = 20 * int'(d2) + 2 * int'(d1) + ((int'(d0) >= 5) ? 1 : 0);
        if (n && h > 120) h = 120;
        if (!n && h > 24) h = 24;
        e = (n ? -1.0 : 1.0) * real'(h) / 40.0;
        return $rtoi(8192.0 * (10.0 ** e) + 0.5);
    endfunction

    function automatic int gain_apply(input int x, input int g, output bit c);
        real y;
        y = $floor((real'(x) * real'(g) + 4096.0) / 8192.0);
        c = 1'b0;
        if (y > 32767.0) begin
            c = 1'b1;
            return 32767;
        end
        if (y < -32768.0) begin
            c = 1'b1;
            return -32768;
        end
        return $rtoi(y);
    endfunction

    // Reference model state
    int m_target, m_gain, m_out, m_x, m_g, m_run, m_prev;
    bit m_clip, m_ramp, m_bad;
    bit m_valid = 1'b0;

    always @(posedge clk_48) begin
        int w, eff, d;
        bit same;
        w = int'({bus.neg, bus.num2, bus.num1, bus.num0});
        if (reset) begin
            m_target = 8192; m_gain = 0; m_out = 0; m_clip = 0; m_ramp = 0;
            m_bad = 0; m_run = 0; m_prev = 0; m_x = 0; m_g = 0; m_valid = 1;
        end else begin
            eff    = bus.mute ? 0 : m_target;
            m_out  = gain_apply(m_x, m_g, m_clip);
            m_x    = int'(bus.inWave);
            m_g    = m_gain;
            d      = eff - m_gain;
            if (d > 64) d = 64;
            else if (d < -64) d = -64;
            m_gain = m_gain + d;
            m_ramp = (m_gain != eff);
            same   = (w == m_prev);
            if (same && m_run == 479) begin
                if (bus.num2 > 9 || bus.num1 > 9 || bus.num0 > 9) begin
                    m_bad = 1;
                end else begin
                    m_bad    = 0;
                    m_target = rom_ref(bus.neg, bus.num2, bus.num1, bus.num0);
                end
            end
            m_run  = same ? ((m_run < 480) ? m_run + 1 : 480) : 0;
            m_prev = w;
        end
    end

    always @(negedge clk_48) begin
        if (m_valid) begin
            check("model_outWave", int'(bus.outWave), m_out);
            check("model_clip",    int'(bus.clip),    int'(m_clip));
            check("model_gain_q",  int'(bus.gain_q),  m_gain);
            check("model_ramping", int'(bus.ramping), int'(m_ramp));
            check("model_bad_set", int'(bus.bad_set), int'(m_bad));
        end
    end

    typedef struct {
        bit         neg;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        int         in;
        int         out;
        bit         clip;
        int         gain;
    } vec_t;

    task automatic set_word(input bit n, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0);
        bus.neg = n; bus.num2 = d2; bus.num1 = d1; bus.num0 = d0;
    endtask

    vec_t vecs [12];

    initial begin
        logic [12:0] cur;
        vecs[0]  = '{0, 4'd0, 4'd0, 4'd0,  16384,  16384, 0,  8192};
        vecs[1]  = '{0, 4'd0, 4'd0, 4'd0,  -4277,  -4277, 0,  8192};
        vecs[2]  = '{0, 4'd0, 4'd0, 4'd5,   8192,   8677, 0,  8677};
        vecs[3]  = '{1, 4'd0, 4'd0, 4'd4,   1234,   1234, 0,  8192};
        vecs[4]  = '{1, 4'd0, 4'd6, 4'd0,  32767,  16423, 0,  4106};
        vecs[5]  = '{1, 4'd0, 4'd6, 4'd0, -32767, -16423, 0,  4106};
        vecs[6]  = '{0, 4'd1, 4'd2, 4'd0,  16384,  32767, 1, 32613};
        vecs[7]  = '{0, 4'd1, 4'd2, 4'd0, -16384, -32768, 1, 32613};
        vecs[8]  = '{0, 4'd1, 4'd2, 4'd0,   2000,   7962, 0, 32613};
        vecs[9]  = '{1, 4'd0, 4'd3, 4'd0,  10000,   7079, 0,  5799};
        vecs[10] = '{1, 4'd9, 4'd9, 4'd9,  32767,     32, 0,     8};
        vecs[11] = '{1, 4'd9, 4'd9, 4'd9, -32768,    -32, 0,     8};

        bus.inWave = '0;
        bus.mute   = 1'b0;
        set_word(0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        tick(2);
        check("reset_gain_q",  int'(bus.gain_q),  0);
        check("reset_outWave", int'(bus.outWave), 0);
        check("reset_ramping", int'(bus.ramping), 0);
        check("reset_clip",    int'(bus.clip),    0);
        check("reset_bad_set", int'(bus.bad_set), 0);

        // Soft start to unity
        reset = 1'b0;
        tick(1);
        check("soft_first_gain", int'(bus.gain_q), 64);
        check("soft_first_ramp", int'(bus.ramping), 1);
        tick(126);
        check("soft_127_gain", int'(bus.gain_q), 8128);
        check("soft_127_ramp", int'(bus.ramping), 1);
        tick(1);
        check("soft_128_gain", int'(bus.gain_q), 8192);
        check("soft_128_ramp", int'(bus.ramping), 0);

        // Directed datapath vectors at settled gains
        cur = 13'd0;
        for (int i = 0; i < 12; i++) begin
            if ({vecs[i].neg, vecs[i].d2, vecs[i].d1, vecs[i].d0} != cur) begin
                set_word(vecs[i].neg, vecs[i].d2, vecs[i].d1, vecs[i].d0);
                cur = {vecs[i].neg, vecs[i].d2, vecs[i].d1, vecs[i].d0};
                tick(1100);
            end
            check("vec_gain", int'(bus.gain_q), vecs[i].gain);
            bus.inWave = 16'(vecs[i].in);
            tick(2);
            check("vec_outWave", int'(bus.outWave), vecs[i].out);
            check("vec_clip",    int'(bus.clip),    int'(vecs[i].clip));
        end

        // Debounce: a word toggling every 100 clocks never settles
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) set_word(0, 4'd0, 4'd0, 4'd0);
            else            set_word(0, 4'd1, 4'd2, 4'd0);
            tick(100);
        end
        check("toggle_gain", int'(bus.gain_q), 8);
        check("toggle_ramp", int'(bus.ramping), 0);

        // Non-BCD digit flags bad_set and keeps the target
        set_word(1, 4'd0, 4'hA, 4'd0);
        tick(600);
        check("bad_flag", int'(bus.bad_set), 1);
        check("bad_gain", int'(bus.gain_q), 8);
        set_word(1, 4'd0, 4'd3, 4'd0);
        tick(700);
        check("recover_bad", int'(bus.bad_set), 0);
        check("recover_gain", int'(bus.gain_q), 5799);

        // Mute ramps to zero and back without re-settling
        set_word(0, 4'd0, 4'd0, 4'd0);
        tick(600);
        check("pre_mute_gain", int'(bus.gain_q), 8192);
        bus.mute = 1'b1;
        tick(1);
        check("mute_first", int'(bus.gain_q), 8128);
        tick(127);
        check("mute_zero", int'(bus.gain_q), 0);
        bus.inWave = 16'sd12345;
        tick(2);
        check("mute_out", int'(bus.outWave), 0);
        bus.mute = 1'b0;
        tick(128);
        check("unmute_gain", int'(bus.gain_q), 8192);
        check("unmute_ramp", int'(bus.ramping), 0);

        // Reset mid-ramp discards everything, then soft start repeats
        bus.mute = 1'b1;
        tick(30);
        check("midramp_gain", int'(bus.gain_q), 8192 - 30 * 64);
        reset = 1'b1;
        tick(1);
        check("midreset_gain", int'(bus.gain_q), 0);
        check("midreset_out",  int'(bus.outWave), 0);
        check("midreset_ramp", int'(bus.ramping), 0);
        reset = 1'b0;
        bus.mute = 1'b0;
        tick(1);
        check("restart_gain", int'(bus.gain_q), 64);
        check("restart_ramp", int'(bus.ramping), 1);

        // Randomized settings, mute and audio checked by the lockstep model
        for (int s = 0; s < 24; s++) begin
            logic [3:0] dg [3];
            int hold;
            for (int j = 0; j < 3; j++) begin
                dg[j] = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 9))
                                                    : 4'($urandom_range(0, 15));
            end
            set_word(1'($urandom_range(0, 1)), dg[0], dg[1], dg[2]);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300))
                                               : int'($urandom_range(480, 700));
            for (int c = 0; c < hold; c++) begin
                bus.inWave = 16'($urandom);
                if ($urandom_range(0, 299) == 0) bus.mute = ~bus.mute;
                reset = ($urandom_range(0, 5999) == 0);
                tick(1);
            end
            reset = 1'b0;
        end
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
